reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 19 +
 rtl/reg_file_scoreboard.sv | 61 ++++++
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared constants and helpers for the scoreboarded register file.
//   DefWidth / DefDepth : default data width and register count.
//   calc_addr_w()       : address width for a power-of-two register count.
package reg_file_sb_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 8;

  // log2 of a power-of-two depth in 2..64; evaluated at elaboration time.
  function automatic int unsigned calc_addr_w(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 7; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: pending-bit vector plus a registered population count.
//   clock, resetN : clock and asynchronous active-low reset.
//   set_en_i/set_idx_i : mark a register as awaiting a result (issue).
//   clr_en_i/clr_idx_i : clear a register's pending bit (writeback).
//   pending_o : one pending bit per register.
//   count_o   : number of set pending bits, 0..DEPTH.
module reg_file_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DEPTH    = DefDepth,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned ADDR_W  = calc_addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  output logic [DEPTH-1:0]  pending_o,
  output logic [ADDR_W:0]   count_o
);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             set_eff, clr_eff, inc, dec;

  always_comb begin
    set_eff   = set_en_i && !(ZERO_REG && (set_idx_i == '0));
    clr_eff   = clr_en_i && !(ZERO_REG && (clr_idx_i == '0));
    pending_d = pending_q;
    // Clear first so a same-edge issue to the same register wins.
    if (clr_eff) pending_d[clr_idx_i] = 1'b0;
    if (set_eff) pending_d[set_idx_i] = 1'b1;

    inc = set_eff && !pending_q[set_idx_i];
    // A clear that is immediately re-set leaves the bit set: no decrement.
    dec = clr_eff && pending_q[clr_idx_i] && !(set_eff && (set_idx_i == clr_idx_i));

    count_d = count_q;
    case ({inc, dec})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register pending scoreboard.
//   clock, resetN      : clock and asynchronous active-low reset.
//   writeEnable/writeRegister/writeData : writeback port; clears the pending bit.
//   issueEnable/issueRegister           : marks a register as awaiting a result.
//   readRegister1/2 -> readData1/2, busy1/2 : two independent combinational read ports.
//   pendingCount       : number of pending registers.
// Build option: define REG_FILE_SB_BYPASS_EN to forward same-cycle writeback data to the
// read ports (busy then reflects only a same-cycle issue to that register).
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned ADDR_W  = calc_addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              issueEnable,
  input  logic [ADDR_W-1:0] issueRegister,
  input  logic [ADDR_W-1:0] readRegister1,
  input  logic [ADDR_W-1:0] readRegister2,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pendingCount
);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [DEPTH-1:0]          pending;
  logic                      mem_we;
  logic [1:0][ADDR_W-1:0]    raddr;
  logic [1:0][WIDTH-1:0]     rdata;
  logic [1:0]                rbusy;

  assign mem_we = writeEnable && !(ZERO_REG && (writeRegister == '0));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[writeRegister] <= writeData;
    end
  end

  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock     (clock),
    .resetN    (resetN),
    .set_en_i  (issueEnable),
    .set_idx_i (issueRegister),
    .clr_en_i  (writeEnable),
    .clr_idx_i (writeRegister),
    .pending_o (pending),
    .count_o   (pendingCount)
  );

  assign raddr[0] = readRegister1;
  assign raddr[1] = readRegister2;

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem_q[raddr[p]];
      rbusy[p] = pending[raddr[p]];
`ifdef REG_FILE_SB_BYPASS_EN
      if (writeEnable && (writeRegister == raddr[p])) begin
        rdata[p] = writeData;
        rbusy[p] = issueEnable && (issueRegister == raddr[p]);
      end
`endif
      // Reset and the hardwired zero register override everything, including forwarding.
      if (!resetN || (ZERO_REG && (raddr[p] == '0))) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign readData1 = rdata[0];
  assign readData2 = rdata[1];
  assign busy1     = rbusy[0];
  assign busy2     = rbusy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 3;

  logic          clock = 1'b0;
  logic          resetN;
  logic          we, ie;
  logic [AW-1:0] wa, ia, ra1, ra2;
  logic [W-1:0]  wd;
  logic [W-1:0]  rd1, rd2, nz_rd1, nz_rd2;
  logic          b1, b2, nz_b1, nz_b2;
  logic [AW:0]   cnt, nz_cnt;

  always #5 clock = ~clock;

  reg_file_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1)) dut (
    .clock(clock), .resetN(resetN),
    .writeEnable(we), .writeRegister(wa), .writeData(wd),
    .issueEnable(ie), .issueRegister(ia),
    .readRegister1(ra1), .readRegister2(ra2),
    .readData1(rd1), .readData2(rd2), .busy1(b1), .busy2(b2),
    .pendingCount(cnt)
  );

  reg_file_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b0)) dut_nz (
    .clock(clock), .resetN(resetN),
    .writeEnable(we), .writeRegister(wa), .writeData(wd),
    .issueEnable(ie), .issueRegister(ia),
    .readRegister1(ra1), .readRegister2(ra2),
    .readData1(nz_rd1), .readData2(nz_rd2), .busy1(nz_b1), .busy2(nz_b2),
    .pendingCount(nz_cnt)
  );

  // Reference model of the ZERO_REG=1 instance.
  logic [W-1:0] m_mem [D];
  bit           m_pend [D];

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic push_exp(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.v);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (!resetN || a == '0) return '0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!resetN || a == '0) return 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (we && wa == a) return ie && (ia == a);
`endif
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < D; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (we && wa != '0) begin
      m_mem[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (ie && ia != '0) m_pend[ia] = 1'b1;
  endtask

  task automatic drive(input logic w_en, input logic [AW-1:0] w_a, input logic [W-1:0] w_d,
                       input logic i_en, input logic [AW-1:0] i_a,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    we = w_en; wa = w_a; wd = w_d; ie = i_en; ia = i_a; ra1 = r1; ra2 = r2;
  endtask

  // Called just after a falling edge with inputs set: checks outputs, then crosses one edge.
  task automatic cycle(input string ph);
    push_exp({ph, ".rd1"},  64'(exp_rd(ra1)));
    push_exp({ph, ".rd2"},  64'(exp_rd(ra2)));
    push_exp({ph, ".busy1"}, 64'(exp_busy(ra1)));
    push_exp({ph, ".busy2"}, 64'(exp_busy(ra2)));
    push_exp({ph, ".cnt"},  64'(exp_cnt()));
    #1;
    pop_check(64'(rd1));
    pop_check(64'(rd2));
    pop_check(64'(b1));
    pop_check(64'(b2));
    pop_check(64'(cnt));
    @(posedge clock);
    if (resetN) model_edge();
    @(negedge clock);
  endtask

  initial begin
    resetN = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    model_reset();
    @(negedge clock);

    // Writes and issues are ignored while reset is held.
    drive(1'b1, 3'd3, 8'h77, 1'b1, 3'd3, 3'd3, 3'd3);
    cycle("in_reset");
    resetN = 1'b1;

    // Write 0x5A to r3 while issuing r5, then assert reset mid-cycle.
    drive(1'b1, 3'd3, 8'h5A, 1'b1, 3'd5, 3'd3, 3'd5);
    cycle("wr_r3");
    drive(1'b0, '0, '0, 1'b0, '0, 3'd3, 3'd5);
    cycle("rd_r3");
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    push_exp("rst_mid.rd1", 64'h0);
    push_exp("rst_mid.cnt", 64'h0);
    push_exp("rst_mid.busy2", 64'h0);
    pop_check(64'(rd1));
    pop_check(64'(cnt));
    pop_check(64'(b2));
    @(negedge clock);
    cycle("rst_hold");
    resetN = 1'b1;

    // Write/read on both ports.
    drive(1'b1, 3'd5, 8'hA5, 1'b0, '0, 3'd5, 3'd5);
    cycle("wr_r5");
    drive(1'b0, '0, '0, 1'b0, '0, 3'd5, 3'd5);
    cycle("rd_r5");

    // Scoreboard sequence.
    drive(1'b0, '0, '0, 1'b1, 3'd2, 3'd2, 3'd4);
    cycle("iss_r2");
    drive(1'b0, '0, '0, 1'b1, 3'd4, 3'd2, 3'd4);
    cycle("iss_r4");
    drive(1'b0, '0, '0, 1'b1, 3'd4, 3'd2, 3'd4);
    cycle("reiss_r4");
    drive(1'b1, 3'd2, 8'h22, 1'b0, '0, 3'd2, 3'd4);
    cycle("wr_r2");
    drive(1'b1, 3'd4, 8'h44, 1'b1, 3'd4, 3'd2, 3'd4);
    cycle("iss_wr_r4");
    drive(1'b1, 3'd7, 8'h17, 1'b0, '0, 3'd4, 3'd7);
    cycle("wr_nonpend_r7");
    drive(1'b0, '0, '0, 1'b0, '0, 3'd4, 3'd7);
    cycle("chk_r4_r7");

    // Zero register.
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0);
    cycle("zero_wr_iss");
    drive(1'b0, '0, '0, 1'b0, '0, 3'd0, 3'd4);
    cycle("zero_rd");

    // Forwarding: r6 holds 0x11 and is pending, then written with 0x3C while read.
    drive(1'b1, 3'd6, 8'h11, 1'b0, '0, 3'd6, 3'd1);
    cycle("wr_r6_old");
    drive(1'b0, '0, '0, 1'b1, 3'd6, 3'd6, 3'd6);
    cycle("iss_r6");
    drive(1'b1, 3'd6, 8'h3C, 1'b0, '0, 3'd6, 3'd6);
    cycle("byp_r6");
    drive(1'b0, '0, '0, 1'b1, 3'd6, 3'd6, 3'd6);
    cycle("iss_r6_again");
    drive(1'b1, 3'd6, 8'h5C, 1'b1, 3'd6, 3'd6, 3'd6);
    cycle("byp_r6_reiss");

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), W'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)),
            AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1)));
      cycle("rand");
    end

    // Saturation on the ZERO_REG=0 instance.
    resetN = 1'b0;
    model_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < D; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), AW'(i), 3'd0);
      cycle("sat_iss");
      push_exp("sat_iss.nz_cnt", 64'(i + 1));
      pop_check(64'(nz_cnt));
    end
    drive(1'b0, '0, '0, 1'b0, '0, 3'd0, 3'd7);
    push_exp("sat_full.nz_busy1", 64'h1);
    push_exp("sat_full.nz_busy2", 64'h1);
    #1;
    pop_check(64'(nz_b1));
    pop_check(64'(nz_b2));
    for (int i = 0; i < D; i++) begin
      drive(1'b1, AW'(i), W'(8'hC0 + i), 1'b0, '0, AW'(i), 3'd0);
      cycle("sat_wr");
      push_exp("sat_wr.nz_cnt", 64'(D - 1 - i));
      pop_check(64'(nz_cnt));
    end
    drive(1'b0, '0, '0, 1'b0, '0, 3'd0, 3'd7);
    push_exp("sat_done.nz_rd1", 64'hC0);
    push_exp("sat_done.nz_rd2", 64'hC7);
    #1;
    pop_check(64'(nz_rd1));
    pop_check(64'(nz_rd2));

    if (exp_q.size() != 0) check_val("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
